// File: rtl/key_mode_ctrl_if.sv
// Key/frame input bundle and mode status outputs of key_mode_ctrl.
// The controller uses the slave modport; the stimulus side uses master.
interface key_mode_ctrl_if;
  logic [1:0] key_down;
  logic       frame_start;
  logic [2:0] mode;
  logic       mode_upd;
  logic       busy;
  logic       overflow;

  modport master (
    output key_down, frame_start,
    input  mode, mode_upd, busy, overflow
  );

  modport slave (
    input  key_down, frame_start,
    output mode, mode_upd, busy, overflow
  );
endinterface

// File: rtl/key_mode_ctrl.sv
// Display-mode controller: NEXT/PREV key commands are queued and applied one per frame.
// Optional auto-advance after AUTO_FRAMES idle frames is built only with KEY_AUTO_CYCLE_EN.
module key_mode_ctrl #(
  parameter int MODE_NUM    = 8,
  parameter int AUTO_FRAMES = 120
) (
  input logic            clk,
  input logic            rst_n,
  key_mode_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  localparam logic [2:0] MODE_MAX = 3'(MODE_NUM - 1);

  state_t     state_r, state_s;
  logic       fifo_r [4];
  logic [1:0] rd_ptr_r, wr_ptr_r;
  logic [2:0] count_r, count_nxt_s;
  logic       cmd_r;
  logic [2:0] mode_r;
  logic       mode_upd_r, busy_r, overflow_r;

  logic key_push_s, auto_push_s, push_req_s, push_cmd_s;
  logic pop_s, full_s, push_ok_s, drop_s;

  // Step the mode by one position with wrap-around; cmd 0 = NEXT, 1 = PREV.
  function automatic logic [2:0] mode_step(input logic [2:0] cur, input logic cmd);
    logic [2:0] res;
    if (cmd == 1'b0) begin
      res = (cur == MODE_MAX) ? 3'd0 : cur + 3'd1;
    end else begin
      res = (cur == 3'd0) ? MODE_MAX : cur - 3'd1;
    end
    return res;
  endfunction

`ifdef KEY_AUTO_CYCLE_EN
  localparam int FCW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  logic [FCW-1:0] frame_cnt_r;

  assign auto_push_s = (state_r == ST_IDLE) && bus.frame_start &&
                       (bus.key_down == 2'b00) && (frame_cnt_r == FCW'(AUTO_FRAMES - 1));

  // Idle-frame counter: any key activity restarts it, it only advances in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r <= '0;
    end else if (bus.key_down != 2'b00) begin
      frame_cnt_r <= '0;
    end else if ((state_r == ST_IDLE) && bus.frame_start) begin
      frame_cnt_r <= auto_push_s ? '0 : frame_cnt_r + FCW'(1);
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end
`else
  assign auto_push_s = 1'b0;
`endif

  // Push/pop qualification; a pop in the same cycle frees room for a push into a full queue.
  always_comb begin
    key_push_s  = (bus.key_down == 2'b01) || (bus.key_down == 2'b10);
    push_req_s  = key_push_s || auto_push_s;
    push_cmd_s  = key_push_s ? bus.key_down[1] : 1'b0;
    pop_s       = (state_r == ST_WAIT) && bus.frame_start && (count_r != 3'd0);
    full_s      = (count_r == 3'd4);
    push_ok_s   = push_req_s && (!full_s || pop_s);
    drop_s      = push_req_s && full_s && !pop_s;
    count_nxt_s = count_r + {2'b00, push_ok_s} - {2'b00, pop_s};
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (count_r != 3'd0) state_s = ST_WAIT;
        else                 state_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (pop_s) state_s = ST_APPLY;
        else       state_s = ST_WAIT;
      end
      ST_APPLY: begin
        if (count_r != 3'd0) state_s = ST_WAIT;
        else                 state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Command queue storage, pointers, occupancy and the popped command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) fifo_r[i] <= 1'b0;
      rd_ptr_r <= 2'd0;
      wr_ptr_r <= 2'd0;
      count_r  <= 3'd0;
      cmd_r    <= 1'b0;
    end else begin
      if (push_ok_s) begin
        fifo_r[wr_ptr_r] <= push_cmd_s;
        wr_ptr_r         <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        cmd_r    <= fifo_r[rd_ptr_r];
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      count_r <= count_nxt_s;
    end
  end

  // Registered outputs; busy is computed from next-cycle occupancy and state so it is current.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r     <= 3'd0;
      mode_upd_r <= 1'b0;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (state_r == ST_APPLY) begin
        mode_r     <= mode_step(mode_r, cmd_r);
        mode_upd_r <= 1'b1;
      end else begin
        mode_upd_r <= 1'b0;
      end
      busy_r     <= (count_nxt_s != 3'd0) || (state_s == ST_APPLY);
      overflow_r <= drop_s;
    end
  end

  assign bus.mode     = mode_r;
  assign bus.mode_upd = mode_upd_r;
  assign bus.busy     = busy_r;
  assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Self-checking bench for key_mode_ctrl: directed scenarios then randomized rounds against a queue model.
// Auto-advance scenarios are exercised when KEY_AUTO_CYCLE_EN is defined.
module tb_key_mode_ctrl;
  localparam int MN = 8;
`ifdef KEY_AUTO_CYCLE_EN
  localparam int AF = 3;
`else
  localparam int AF = 120;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  key_mode_ctrl_if bus();

  key_mode_ctrl #(.MODE_NUM(MN), .AUTO_FRAMES(AF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: pending commands, current mode, idle frame count.
  bit q[$];
  int m_mode   = 0;
  int idle_cnt = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int apply_cmd(input int m, input bit c);
    return (c == 1'b0) ? (m + 1) % MN : (m + MN - 1) % MN;
  endfunction

  task automatic model_reset();
    q.delete();
    m_mode   = 0;
    idle_cnt = 0;
  endtask

  // One key press cycle followed by one quiet cycle.
  task automatic push(input logic [1:0] kd);
    logic exp_ovf;
    exp_ovf = 1'b0;
    bus.key_down = kd;
    step();
    bus.key_down = 2'b00;
    if (kd != 2'b00) idle_cnt = 0;
    if (kd == 2'b01 || kd == 2'b10) begin
      if (q.size() == 4) exp_ovf = 1'b1;
      else q.push_back(kd == 2'b10);
    end
    chk("push_ovf", {7'd0, bus.overflow}, {7'd0, exp_ovf});
    chk("push_busy", {7'd0, bus.busy}, 8'(q.size() != 0));
    chk("push_mode", {5'd0, bus.mode}, 8'(m_mode));
    chk("push_upd", {7'd0, bus.mode_upd}, 8'd0);
    step();
    chk("push_ovf_clr", {7'd0, bus.overflow}, 8'd0);
  endtask

  // One frame_start (optionally with a key press), then observe the two following cycles.
  task automatic do_frame(input logic [1:0] kd);
    bit   popped;
    bit   c;
    logic exp_ovf;
    popped  = 1'b0;
    c       = 1'b0;
    exp_ovf = 1'b0;
    bus.frame_start = 1'b1;
    bus.key_down    = kd;
    step();
    bus.frame_start = 1'b0;
    bus.key_down    = 2'b00;
    if (q.size() != 0) begin
      c      = q.pop_front();
      popped = 1'b1;
    end else if (kd == 2'b00) begin
`ifdef KEY_AUTO_CYCLE_EN
      idle_cnt++;
      if (idle_cnt == AF) begin
        q.push_back(1'b0);
        idle_cnt = 0;
      end
`endif
    end
    if (kd != 2'b00) idle_cnt = 0;
    if (kd == 2'b01 || kd == 2'b10) begin
      if (q.size() == 4) exp_ovf = 1'b1;
      else q.push_back(kd == 2'b10);
    end
    chk("frm_ovf", {7'd0, bus.overflow}, {7'd0, exp_ovf});
    chk("frm_early_upd", {7'd0, bus.mode_upd}, 8'd0);
    chk("frm_early_mode", {5'd0, bus.mode}, 8'(m_mode));
    step();
    if (popped) m_mode = apply_cmd(m_mode, c);
    chk("frm_mode", {5'd0, bus.mode}, 8'(m_mode));
    chk("frm_upd", {7'd0, bus.mode_upd}, {7'd0, popped});
    chk("frm_busy", {7'd0, bus.busy}, 8'(q.size() != 0));
    step();
    chk("frm_upd_clr", {7'd0, bus.mode_upd}, 8'd0);
    chk("frm_ovf_clr", {7'd0, bus.overflow}, 8'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.key_down    = 2'b00;
    bus.frame_start = 1'b0;
    model_reset();
    repeat (3) step();
    chk("rst_mode", {5'd0, bus.mode}, 8'd0);
    chk("rst_upd", {7'd0, bus.mode_upd}, 8'd0);
    chk("rst_busy", {7'd0, bus.busy}, 8'd0);
    chk("rst_ovf", {7'd0, bus.overflow}, 8'd0);
    rst_n = 1'b1;
    step();

    // Single NEXT applied ten cycles after the press.
    push(2'b01);
    repeat (8) step();
    do_frame(2'b00);
    chk("first_next", {5'd0, bus.mode}, 8'd1);

    // Wrap both directions.
    push(2'b10);
    do_frame(2'b00);
    push(2'b10);
    do_frame(2'b00);
    chk("wrap_prev", {5'd0, bus.mode}, 8'd7);
    push(2'b01);
    do_frame(2'b00);
    chk("wrap_next", {5'd0, bus.mode}, 8'd0);

    // Overflow on the fifth press, then one step per frame, fifth frame idle.
    repeat (5) push(2'b01);
    repeat (5) do_frame(2'b00);
    chk("ovf_seq_mode", {5'd0, bus.mode}, 8'd4);

    // Both keys at once is discarded; full queue with push and pop together keeps four.
    push(2'b11);
    repeat (4) push(2'b01);
    do_frame(2'b01);
    repeat (5) do_frame(2'b00);
    chk("full_pushpop_mode", {5'd0, bus.mode}, 8'd1);

    // Reset in APPLY with three commands still queued.
    repeat (4) push(2'b01);
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("apply_rst_mode", {5'd0, bus.mode}, 8'd0);
    chk("apply_rst_busy", {7'd0, bus.busy}, 8'd0);
    chk("apply_rst_upd", {7'd0, bus.mode_upd}, 8'd0);
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_upd", {7'd0, bus.mode_upd}, 8'd0);
      chk("post_rst_mode", {5'd0, bus.mode}, 8'd0);
      chk("post_rst_busy", {7'd0, bus.busy}, 8'd0);
    end
    do_frame(2'b00);

`ifdef KEY_AUTO_CYCLE_EN
    // Key press after two idle frames restarts the count; third idle frame queues NEXT.
    do_frame(2'b00);
    push(2'b11);
    repeat (3) do_frame(2'b00);
    chk("auto_pending", {5'd0, bus.mode}, 8'd0);
    do_frame(2'b00);
    chk("auto_applied", {5'd0, bus.mode}, 8'd1);
`endif

    // Randomized rounds: bursts of presses, then bursts of frames.
    for (int r = 0; r < 40; r++) begin
      int n;
      int k;
      n = $urandom_range(5, 0);
      for (int i = 0; i < n; i++) push(2'($urandom_range(3, 0)));
      k = $urandom_range(4, 0);
      for (int i = 0; i < k; i++) begin
        if ($urandom_range(3, 0) == 0) do_frame(2'($urandom_range(3, 1)));
        else do_frame(2'b00);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_mode_ctrl.md
KEY_MODE_CTRL -- requirements
Module: key_mode_ctrl

Interface
REQ-001 SHALL have parameter MODE_NUM, default 8: number of display modes, 2..8.
REQ-002 SHALL have parameter AUTO_FRAMES, default 120: idle frames before an auto-advance (used only under KEY_AUTO_CYCLE_EN).
REQ-003 SHALL have port clk  input  1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port key_down  input  2: one-cycle debounced press pulses; bit0 = NEXT, bit1 = PREV.
REQ-006 SHALL have port frame_start  input  1: one-cycle pulse at the start of vertical blanking.
REQ-007 SHALL have port mode  output  3: current display mode, 0..MODE_NUM-1, registered.
REQ-008 SHALL have port mode_upd  output  1: one-cycle pulse in the cycle mode takes a new value.
REQ-009 SHALL have port busy  output  1: high while the command FIFO is non-empty or state is APPLY.
REQ-010 SHALL have port overflow  output  1: one-cycle pulse when a command is dropped because the FIFO is full.

Function
REQ-011 SHALL hold a 4-entry command FIFO of 1-bit entries: 0 = NEXT, 1 = PREV.
REQ-012 SHALL push on key_down == 2'b01 (NEXT) or 2'b10 (PREV); key_down == 2'b11 is discarded, no push, no overflow.
REQ-013 SHALL drop a push when the FIFO is full and no pop occurs in that cycle; overflow pulses in the next cycle.
REQ-014 SHALL accept a push in the same cycle as a pop when the FIFO is full; no overflow.
REQ-015 SHALL implement a state machine with states IDLE, WAIT, APPLY.
REQ-016 SHALL transition IDLE->WAIT when the FIFO becomes non-empty.
REQ-017 SHALL transition WAIT->APPLY on frame_start and pop the FIFO head in that cycle.
REQ-018 SHALL, in APPLY, update mode from the popped command, assert mode_upd in that cycle, and go to WAIT if the FIFO is non-empty, otherwise IDLE.
REQ-019 SHALL have this latency: frame_start at cycle t in WAIT gives the new mode and mode_upd visible at cycle t+2.
REQ-020 SHALL apply at most one command per frame_start.
REQ-021 SHALL ignore frame_start while in IDLE or APPLY, except as stated in REQ-027.
REQ-022 SHALL wrap mode: NEXT at MODE_NUM-1 gives 0; PREV at 0 gives MODE_NUM-1; all other values step by +1/-1.
REQ-023 SHALL keep mode_upd and overflow low in all cycles not defined above.

Reset
REQ-024 SHALL, on rst_n low at any time (including mid-APPLY), immediately force: mode=0, mode_upd=0, busy=0, overflow=0, FIFO empty, state IDLE, frame counter 0.
REQ-025 SHALL discard all pending commands on reset and SHALL NOT generate mode_upd on reset release.

Configuration
REQ-026 SHALL compile auto-advance in only when macro KEY_AUTO_CYCLE_EN is defined.
REQ-027 SHALL, with KEY_AUTO_CYCLE_EN defined: count frame_start pulses in IDLE; on reaching AUTO_FRAMES, at that frame_start push NEXT and clear the counter; any key_down != 0 clears the counter; the counter holds outside IDLE.
REQ-028 SHALL, without KEY_AUTO_CYCLE_EN: contain no frame counter, and change mode only via key_down commands.

Verification
REQ-029 Reset, then key_down=01, then frame_start 10 cycles later -> mode 0->1, mode_upd at frame_start+2, busy low afterwards.
REQ-030 mode=0, key_down=10, then frame_start -> mode=MODE_NUM-1 (7); then mode=7, key_down=01, then frame_start -> mode=0.
REQ-031 Five NEXT pulses with no frame_start -> overflow on the fifth only; 4 frame_starts -> mode 0->1->2->3->4, one step per frame; 5th frame_start -> no change, busy low.
REQ-032 key_down=11 -> no push, busy stays low, mode unchanged; FIFO full, with push and frame_start in the same WAIT cycle -> no overflow, FIFO stays at 4.
REQ-033 rst_n low in APPLY with 3 commands queued -> mode=0, busy=0 immediately; no mode_upd after release.
REQ-034 With KEY_AUTO_CYCLE_EN and AUTO_FRAMES=3: 3 idle frame_starts -> NEXT queued, applied on the 4th frame_start; a key_down after 2 frames restarts the count.
